// File: rtl/tdm_slot_demux.sv
// tdm_slot_demux
// Receive side of a time-shared single-bit link. One serial bit is sampled
// per posedge and the slots are de-interleaved into NUM_CH parallel bits.
// Slot 0 maps to ch_data[0]. A frame-sync input marks slot 0. Flywheel lock
// tracking tolerates up to MISS_LIMIT-1 consecutive missing slot-0 syncs.
//
// Ports:
//   clk          clock, all logic on posedge
//   rst          synchronous reset, active-high
//   din          serial data, one slot per cycle
//   sync_in      high during the slot-0 cycle of each frame
//   ch_data      last complete frame, bit k = slot k (registered)
//   frame_valid  one-cycle pulse when ch_data updates
//   locked       high while in the LOCKED state
//   sync_err     one-cycle pulse on a misaligned sync
//   err_count    misaligned-sync count, saturates at 15
//   frame_count  delivered-frame count, wraps 15 -> 0
//   state_dbg    current FSM state (0 = HUNT, 1 = LOCKED)
//
// Handshake: there is no backpressure. frame_valid is a one-cycle strobe;
// ch_data is stable from that cycle until the next strobe or reset.
module tdm_slot_demux #(
  parameter int NUM_CH     = 2,
  parameter int MISS_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              sync_in,
  output logic [NUM_CH-1:0] ch_data,
  output logic              frame_valid,
  output logic              locked,
  output logic              sync_err,
  output logic [3:0]        err_count,
  output logic [3:0]        frame_count,
  output logic              state_dbg
);

  localparam int SW = $clog2(NUM_CH);
  localparam logic [SW-1:0] SLOT_ZERO = '0;
  localparam logic [SW-1:0] SLOT_ONE  = SW'(1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_CH - 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       slot_q, slot_d;
  logic [NUM_CH-2:0]   shadow_q, shadow_d;
  logic [3:0]          miss_q, miss_d;
  logic [NUM_CH-1:0]   ch_q, ch_d;
  logic                fv_q, fv_d;
  logic                se_q, se_d;
  logic [3:0]          errc_q, errc_d;
  logic [3:0]          frc_q, frc_d;
  logic                miss_last;

  // This missed sync is the one that exhausts the flywheel budget.
  assign miss_last = (({1'b0, miss_q} + 5'd1) == 5'(MISS_LIMIT));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      slot_q   <= '0;
      shadow_q <= '0;
      miss_q   <= '0;
      ch_q     <= '0;
      fv_q     <= 1'b0;
      se_q     <= 1'b0;
      errc_q   <= '0;
      frc_q    <= '0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      miss_q   <= miss_d;
      ch_q     <= ch_d;
      fv_q     <= fv_d;
      se_q     <= se_d;
      errc_q   <= errc_d;
      frc_q    <= frc_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    shadow_d = shadow_q;
    miss_d   = miss_q;
    ch_d     = ch_q;
    fv_d     = 1'b0;
    se_d     = 1'b0;
    errc_d   = errc_q;
    frc_d    = frc_q;
    case (state_q)
      HUNT: begin
        if (sync_in) begin
          shadow_d[0] = din;
          slot_d      = SLOT_ONE;
          miss_d      = '0;
          state_d     = LOCKED;
        end else begin
          slot_d = SLOT_ZERO;
        end
      end
      LOCKED: begin
        if (sync_in && (slot_q != SLOT_ZERO)) begin
          // Misaligned sync: realign on this cycle, drop the partial frame.
          shadow_d[0] = din;
          slot_d      = SLOT_ONE;
          miss_d      = '0;
          se_d        = 1'b1;
          if (errc_q != 4'hF) errc_d = errc_q + 4'd1;
        end else if (slot_q == SLOT_ZERO) begin
          if (!sync_in && miss_last) begin
            state_d = HUNT;
            miss_d  = '0;
          end else begin
            // Flywheel: a missing sync still takes the sample as slot 0.
            miss_d      = sync_in ? 4'd0 : (miss_q + 4'd1);
            shadow_d[0] = din;
            slot_d      = SLOT_ONE;
          end
        end else if (slot_q == SLOT_LAST) begin
          ch_d   = {din, shadow_q};
          fv_d   = 1'b1;
          frc_d  = frc_q + 4'd1;
          slot_d = SLOT_ZERO;
        end else begin
          for (int k = 0; k < NUM_CH - 1; k++) begin
            if (slot_q == SW'(k)) shadow_d[k] = din;
          end
          slot_d = slot_q + SLOT_ONE;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // Outputs, all taken from registers
  always_comb begin
    ch_data     = ch_q;
    frame_valid = fv_q;
    sync_err    = se_q;
    err_count   = errc_q;
    frame_count = frc_q;
    locked      = (state_q == LOCKED);
    state_dbg   = state_q;
  end

endmodule

// File: tb/tb_tdm_slot_demux.sv
// Testbench for tdm_slot_demux (NUM_CH=2, MISS_LIMIT=3).
module tb_tdm_slot_demux;
  localparam int NUM_CH     = 2;
  localparam int MISS_LIMIT = 3;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic sync_in = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_CH-1:0] ch_data;
  logic              frame_valid, locked, sync_err, state_dbg;
  logic [3:0]        err_count, frame_count;

  tdm_slot_demux #(.NUM_CH(NUM_CH), .MISS_LIMIT(MISS_LIMIT)) dut (
    .clk(clk), .rst(rst), .din(din), .sync_in(sync_in),
    .ch_data(ch_data), .frame_valid(frame_valid), .locked(locked),
    .sync_err(sync_err), .err_count(err_count), .frame_count(frame_count),
    .state_dbg(state_dbg)
  );

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the frame is a list of bits collected since the
  // current frame started; an empty list means the next bit is slot 0.
  logic    m_locked = 1'b0;
  logic    m_bits[$];
  int      m_miss = 0;
  logic [NUM_CH-1:0] exp_ch = '0;
  logic    exp_fv = 1'b0, exp_se = 1'b0;
  int      exp_err = 0, exp_fc = 0;

  task automatic model(input logic r, input logic s, input logic d);
    logic [NUM_CH-1:0] w;
    exp_fv = 1'b0;
    exp_se = 1'b0;
    if (r) begin
      m_locked = 1'b0; m_bits.delete(); m_miss = 0;
      exp_ch = '0; exp_err = 0; exp_fc = 0;
    end else if (!m_locked) begin
      if (s) begin
        m_locked = 1'b1; m_bits.delete(); m_bits.push_back(d); m_miss = 0;
      end
    end else if (s && m_bits.size() != 0) begin
      exp_se = 1'b1;
      exp_err = (exp_err >= 15) ? 15 : exp_err + 1;
      m_bits.delete(); m_bits.push_back(d); m_miss = 0;
    end else if (m_bits.size() == 0) begin
      if (!s && (m_miss + 1 == MISS_LIMIT)) begin
        m_locked = 1'b0; m_miss = 0;
      end else begin
        m_miss = s ? 0 : m_miss + 1;
        m_bits.push_back(d);
      end
    end else begin
      m_bits.push_back(d);
      if (m_bits.size() == NUM_CH) begin
        for (int k = 0; k < NUM_CH; k++) w[k] = m_bits[k];
        exp_ch = w;
        exp_fv = 1'b1;
        exp_fc = (exp_fc + 1) % 16;
        m_bits.delete();
      end
    end
  endtask

  // Driver: apply one cycle of inputs, advance the model, return just
  // after the sampling edge.
  task automatic step(input logic r, input logic s, input logic d);
    @(negedge clk);
    rst = r; sync_in = s; din = d;
    model(r, s, d);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare every cycle against the model.
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      chk("ch_data", 32'(ch_data), 32'(exp_ch));
      chk("frame_valid", 32'(frame_valid), 32'(exp_fv));
      chk("locked", 32'(locked), 32'(m_locked));
      chk("sync_err", 32'(sync_err), 32'(exp_se));
      chk("err_count", 32'(err_count), 32'(exp_err));
      chk("frame_count", 32'(frame_count), 32'(exp_fc));
      chk("state_dbg", 32'(state_dbg), 32'(m_locked));
    end
  end

  initial begin
    int phase;
    logic s;
    // 1. Reset with random inputs
    repeat (2) step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk("rst_ch", 32'(ch_data), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_fc", 32'(frame_count), 32'h0);
    chk("rst_err", 32'(err_count), 32'h0);

    // 2. Acquire
    step(1'b0, 1'b1, 1'b1);
    chk("acq_locked", 32'(locked), 32'h1);
    chk("acq_fv0", 32'(frame_valid), 32'h0);
    step(1'b0, 1'b0, 1'b0);
    chk("acq_ch", 32'(ch_data), 32'h1);
    chk("acq_fv", 32'(frame_valid), 32'h1);
    chk("acq_fc", 32'(frame_count), 32'h1);

    // 3. Stream three frames
    step(1'b0, 1'b1, 1'b1);
    chk("acq_fv_pulse", 32'(frame_valid), 32'h0);
    step(1'b0, 1'b0, 1'b1);
    chk("str_ch11", 32'(ch_data), 32'h3);
    step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b1);
    chk("str_ch10", 32'(ch_data), 32'h2);
    step(1'b0, 1'b1, 1'b1); step(1'b0, 1'b0, 1'b0);
    chk("str_ch01", 32'(ch_data), 32'h1);
    chk("str_fc", 32'(frame_count), 32'h4);

    // 4. Misaligned sync on a slot-1 cycle
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    chk("mis_se", 32'(sync_err), 32'h1);
    chk("mis_err", 32'(err_count), 32'h1);
    chk("mis_fv", 32'(frame_valid), 32'h0);
    step(1'b0, 1'b0, 1'b0);
    chk("mis_ch", 32'(ch_data), 32'h1);
    chk("mis_fv1", 32'(frame_valid), 32'h1);
    chk("mis_se_pulse", 32'(sync_err), 32'h0);

    // 5. Flywheel, then loss of lock and relock
    step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1);
    chk("fly_ch11", 32'(ch_data), 32'h3);
    chk("fly_locked1", 32'(locked), 32'h1);
    step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b1);
    chk("fly_ch10", 32'(ch_data), 32'h2);
    step(1'b0, 1'b0, 1'b1);
    chk("loss_locked", 32'(locked), 32'h0);
    chk("loss_fv", 32'(frame_valid), 32'h0);
    step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b1);
    chk("relock_ch", 32'(ch_data), 32'h2);
    chk("relock_fv", 32'(frame_valid), 32'h1);

    // 6. Reset mid-frame
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("rmid_ch", 32'(ch_data), 32'h0);
    chk("rmid_fc", 32'(frame_count), 32'h0);
    step(1'b0, 1'b0, 1'b1);
    chk("rmid_fv", 32'(frame_valid), 32'h0);
    chk("rmid_locked", 32'(locked), 32'h0);

    // Saturation: lock, then 17 consecutive misaligned syncs
    step(1'b0, 1'b1, 1'b0);
    repeat (17) step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
    chk("sat_err", 32'(err_count), 32'hF);

    // Wrap: 17 delivered frames after reset
    step(1'b1, 1'b0, 1'b0);
    repeat (17) begin
      step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end
    chk("wrap_fc", 32'(frame_count), 32'h1);

    // Random stream: mostly aligned syncs with drops, stray syncs, resets
    phase = 0;
    for (int i = 0; i < 3000; i++) begin
      if (phase == 0) s = ($urandom_range(0, 9) != 0);
      else            s = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 249) == 0) begin
        step(1'b1, s, 1'($urandom_range(0, 1)));
        phase = 0;
      end else begin
        step(1'b0, s, 1'($urandom_range(0, 1)));
        phase = (phase + 1) % NUM_CH;
        if (s && $urandom_range(0, 3) == 0) phase = 1 % NUM_CH;
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
